controller_ec1: RTL and testbench

//  Control unit for the EC-1 datapath (DATAPATH_EC1). A Moore FSM sequences fetch, decode and execute.

---
 rtl/controller_ec1.sv | 172 +++++++++++++++++
 tb/tb_controller_ec1.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/controller_ec1.sv
// controller_ec1 -- Moore control FSM for the EC-1 datapath.
// Sequences fetch / decode / execute, drives the datapath mux and load
// strobes from the state register, and handshakes the Enter key for IN.
// Optional feature macro: EC1_SINGLE_STEP_EN (adds the Step port and a
// STEP_WAIT state so that one instruction runs per Step press).
module controller_ec1 #(
   parameter int SYNC_STAGES = 2  // synchronizer depth, legal 2..4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [2:0] IR75,
   input  logic       Aneq0,
   input  logic       Enter,
`ifdef EC1_SINGLE_STEP_EN
   input  logic       Step,
`endif
   output logic       INmux,
   output logic       Aload,
   output logic       IRload,
   output logic       PCload,
   output logic       JNZmux,
   output logic       OutStrobe,
   output logic       Halt
);

   localparam logic [2:0] OP_HALT = 3'b000;
   localparam logic [2:0] OP_IN   = 3'b011;
   localparam logic [2:0] OP_OUT  = 3'b100;
   localparam logic [2:0] OP_DEC  = 3'b101;
   localparam logic [2:0] OP_JNZ  = 3'b110;
   localparam logic [2:0] OP_JMP  = 3'b111;

   typedef enum logic [3:0] {
      S_START     = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_IN_WAIT   = 4'd3,
      S_IN_LOAD   = 4'd4,
      S_IN_REL    = 4'd5,
      S_OUT       = 4'd6,
      S_DEC       = 4'd7,
      S_JNZ       = 4'd8,
      S_JMP       = 4'd9,
`ifdef EC1_SINGLE_STEP_EN
      S_HALT      = 4'd10,
      S_STEP_WAIT = 4'd11
`else
      S_HALT      = 4'd10
`endif
   } state_t;

   // Where START and every completed instruction go next: straight to
   // FETCH normally, or park until the next Step press in single-step mode.
`ifdef EC1_SINGLE_STEP_EN
   localparam state_t S_NEXT_INSTR = S_STEP_WAIT;
`else
   localparam state_t S_NEXT_INSTR = S_FETCH;
`endif

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] enter_sync;
   logic                   enter_s;

   // Enter key synchronizer: Enter is a raw asynchronous level.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour; blocking here would
   // collapse the chain into a single flop.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) enter_sync <= '0;
      else       enter_sync <= {enter_sync[SYNC_STAGES-2:0], Enter};
   end

   assign enter_s = enter_sync[SYNC_STAGES-1];

`ifdef EC1_SINGLE_STEP_EN
   logic [SYNC_STAGES-1:0] step_sync;
   logic                   step_s;
   logic                   step_d;
   logic                   step_rise;

   // Step key synchronizer plus one delay flop for 0->1 edge detection.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         step_sync <= '0;
         step_d    <= 1'b0;
      end else begin
         step_sync <= {step_sync[SYNC_STAGES-2:0], Step};
         step_d    <= step_s;
      end
   end

   assign step_s    = step_sync[SYNC_STAGES-1];
   assign step_rise = step_s & ~step_d;
`endif

   // State register; reset abandons any instruction in flight.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= S_START;
      else       state <= state_next;
   end

   // Next-state logic.
   // NOTE: state_next is given a default before the case so that no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = S_START;
      case (state)
         S_START:   state_next = S_NEXT_INSTR;
         S_FETCH:   state_next = S_DECODE;
         S_DECODE: begin
            case (IR75)
               OP_HALT: state_next = S_HALT;
               OP_IN:   state_next = S_IN_WAIT;
               OP_OUT:  state_next = S_OUT;
               OP_DEC:  state_next = S_DEC;
               OP_JNZ:  state_next = S_JNZ;
               OP_JMP:  state_next = S_JMP;
               default: state_next = S_NEXT_INSTR;  // 001/010 are NOPs
            endcase
         end
         S_IN_WAIT: state_next = enter_s ? S_IN_LOAD : S_IN_WAIT;
         S_IN_LOAD: state_next = S_IN_REL;
         // Hold here until the key is released: one load per press.
         S_IN_REL:  state_next = enter_s ? S_IN_REL : S_NEXT_INSTR;
         S_OUT:     state_next = S_NEXT_INSTR;
         S_DEC:     state_next = S_NEXT_INSTR;
         S_JNZ:     state_next = S_NEXT_INSTR;
         S_JMP:     state_next = S_NEXT_INSTR;
         S_HALT:    state_next = S_HALT;
`ifdef EC1_SINGLE_STEP_EN
         S_STEP_WAIT: state_next = step_rise ? S_FETCH : S_STEP_WAIT;
`endif
         default:   state_next = S_START;  // unused encodings recover
      endcase
   end

   // Moore output decode from the state register; the only input-dependent
   // output is PCload in JNZ, gated by Aneq0.
   always_comb begin
      INmux     = 1'b0;
      Aload     = 1'b0;
      IRload    = 1'b0;
      PCload    = 1'b0;
      JNZmux    = 1'b0;
      OutStrobe = 1'b0;
      Halt      = 1'b0;
      case (state)
         S_FETCH: begin
            IRload = 1'b1;
            PCload = 1'b1;
         end
         S_IN_LOAD: begin
            INmux = 1'b1;
            Aload = 1'b1;
         end
         S_OUT:   OutStrobe = 1'b1;
         S_DEC:   Aload     = 1'b1;
         S_JNZ: begin
            JNZmux = 1'b1;
            PCload = Aneq0;
         end
         S_JMP: begin
            JNZmux = 1'b1;
            PCload = 1'b1;
         end
         S_HALT:  Halt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_controller_ec1.sv
// tb_controller_ec1 -- directed test of the EC-1 control FSM.
// Output vector order: {INmux, Aload, IRload, PCload, JNZmux, OutStrobe, Halt}.
module tb_controller_ec1;

   localparam int SYNC = 2;

   localparam logic [6:0] O_ZERO  = 7'b000_0000;
   localparam logic [6:0] O_FETCH = 7'b001_1000;
   localparam logic [6:0] O_IN    = 7'b110_0000;
   localparam logic [6:0] O_DEC   = 7'b010_0000;
   localparam logic [6:0] O_OUT   = 7'b000_0010;
   localparam logic [6:0] O_JNZ_T = 7'b000_1100;
   localparam logic [6:0] O_JNZ_N = 7'b000_0100;
   localparam logic [6:0] O_JMP   = 7'b000_1100;
   localparam logic [6:0] O_HALT  = 7'b000_0001;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [2:0] IR75;
   logic       Aneq0;
   logic       Enter;
`ifdef EC1_SINGLE_STEP_EN
   logic       Step;
`endif
   logic       INmux, Aload, IRload, PCload, JNZmux, OutStrobe, Halt;

   int n_vec = 0;
   int n_err = 0;

   controller_ec1 #(.SYNC_STAGES(SYNC)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .IR75      (IR75),
      .Aneq0     (Aneq0),
      .Enter     (Enter),
`ifdef EC1_SINGLE_STEP_EN
      .Step      (Step),
`endif
      .INmux     (INmux),
      .Aload     (Aload),
      .IRload    (IRload),
      .PCload    (PCload),
      .JNZmux    (JNZmux),
      .OutStrobe (OutStrobe),
      .Halt      (Halt)
   );

   always #5 Clk = ~Clk;

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] outs();
      return {INmux, Aload, IRload, PCload, JNZmux, OutStrobe, Halt};
   endfunction

   // Advance one clock and land just after the edge.
   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic expect_cyc(input string tag, input logic [6:0] exp);
      cyc();
      check(tag, 32'(outs()), 32'(exp));
   endtask

   // Wait at most max_cyc clocks for a given output pattern.
   task automatic wait_for(input string tag, input logic [6:0] pat, input int max_cyc);
      logic found;
      found = 1'b0;
      for (int i = 0; i < max_cyc && !found; i++) begin
         cyc();
         if (outs() === pat) found = 1'b1;
      end
      check(tag, 32'(found), 32'd1);
   endtask

   initial begin
      Reset = 1'b1;
      IR75  = 3'b001;
      Aneq0 = 1'b0;
      Enter = 1'b0;
`ifdef EC1_SINGLE_STEP_EN
      Step  = 1'b0;
`endif
      cyc();
      cyc();
      check("reset_state", 32'(outs()), 32'(O_ZERO));
      Reset = 1'b0;
      check("start_after_reset", 32'(outs()), 32'(O_ZERO));

`ifdef EC1_SINGLE_STEP_EN
      begin
         int nf;
         expect_cyc("step_wait", O_ZERO);
         for (int i = 0; i < 4; i++) expect_cyc("step_idle", O_ZERO);
         for (int press = 0; press < 2; press++) begin
            Step = 1'b1;
            nf = 0;
            for (int i = 0; i < 10; i++) begin
               cyc();
               if (outs() === O_FETCH) nf++;
            end
            check("step_one_instr", 32'(nf), 32'd1);
            Step = 1'b0;
            for (int i = 0; i < 4; i++) expect_cyc("step_released", O_ZERO);
         end
      end
`else
      expect_cyc("fetch_after_start", O_FETCH);

      // Reset asserted in the middle of FETCH: outputs drop at once.
      Reset = 1'b1;
      #1;
      check("reset_mid_fetch", 32'(outs()), 32'(O_ZERO));
      for (int i = 0; i < 5; i++) expect_cyc("reset_hold", O_ZERO);
      Reset = 1'b0;
      check("start_again", 32'(outs()), 32'(O_ZERO));
      expect_cyc("fetch_again", O_FETCH);

      // DEC, DEC, JNZ loop. A starts at 4 so two passes reach zero:
      // pass 1 leaves A=2 (jump taken), pass 2 leaves A=0 (falls through).
      begin
         int a;
         a = 4;
         Aneq0 = 1'b1;
         for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 2; k++) begin
               IR75 = 3'b101;
               expect_cyc("dec_decode", O_ZERO);
               expect_cyc("dec_exec", O_DEC);
               a = a - 1;
               Aneq0 = (a != 0);
               expect_cyc("dec_fetch", O_FETCH);
            end
            IR75 = 3'b110;
            expect_cyc("jnz_decode", O_ZERO);
            expect_cyc((pass == 0) ? "jnz_taken" : "jnz_fallthru",
                       (pass == 0) ? O_JNZ_T : O_JNZ_N);
            expect_cyc("jnz_fetch", O_FETCH);
         end
      end

      // IN: key low 10 cycles, then high 6; one load SYNC+1 cycles after rise.
      begin
         int nload;
         int pos;
         IR75 = 3'b011;
         expect_cyc("in_decode", O_ZERO);
         for (int i = 0; i < 10; i++) expect_cyc("in_wait", O_ZERO);
         Enter = 1'b1;
         nload = 0;
         pos   = 0;
         for (int i = 1; i <= 6; i++) begin
            cyc();
            if (outs() === O_IN) begin
               nload++;
               pos = i;
            end else begin
               check("in_key_held_idle", 32'(outs()), 32'(O_ZERO));
            end
         end
         check("in_load_count", 32'(nload), 32'd1);
         check("in_load_latency", 32'(pos), 32'(SYNC + 1));
         Enter = 1'b0;
         // Release propagates through the synchronizer before FETCH.
         for (int i = 0; i < SYNC; i++) expect_cyc("in_release_wait", O_ZERO);
         expect_cyc("in_fetch", O_FETCH);
      end

      // IN entered with the key already held: loads at once, then waits.
      Enter = 1'b1;
      IR75  = 3'b011;
      wait_for("in_held_load", O_IN, 4);
      Enter = 1'b0;
      wait_for("in_held_fetch", O_FETCH, 8);

      // OUT then JMP.
      IR75 = 3'b100;
      expect_cyc("out_decode", O_ZERO);
      expect_cyc("out_strobe", O_OUT);
      expect_cyc("out_fetch", O_FETCH);
      IR75 = 3'b111;
      expect_cyc("jmp_decode", O_ZERO);
      expect_cyc("jmp_exec", O_JMP);
      expect_cyc("jmp_fetch", O_FETCH);

      // NOP: fetch to fetch in two cycles.
      IR75 = 3'b010;
      expect_cyc("nop_decode", O_ZERO);
      expect_cyc("nop_fetch", O_FETCH);

      // HALT is sticky for 20 cycles and cleared only by Reset.
      IR75 = 3'b000;
      expect_cyc("halt_decode", O_ZERO);
      for (int i = 0; i < 20; i++) expect_cyc("halt_hold", O_HALT);
      Reset = 1'b1;
      #1;
      check("halt_reset_async", 32'(outs()), 32'(O_ZERO));
      cyc();
      Reset = 1'b0;
      IR75  = 3'b001;
      check("halt_start", 32'(outs()), 32'(O_ZERO));
      expect_cyc("halt_refetch", O_FETCH);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
